// File: rtl/csa_resolve.sv
`default_nettype none
// csa_resolve: turns a carry-save (sum, carry) pair into a plain binary value,
// one CHUNK-bit slice per cycle, and holds the result until downstream accepts it.
module csa_resolve #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   s_in,
    input  logic [WIDTH-1:0]   c_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   result
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q;
    logic [N-1:0][CHUNK-1:0]     sum_q;
    logic [N-1:0][CHUNK-1:0]     car_lo_q;
    logic                        car_top_q;
    logic [IW-1:0]               idx_q;
    logic                        cy_q;
    logic [N-1:0][CHUNK-1:0]     res_lo_q;
    logic [1:0]                  res_hi_q;
    logic                        out_valid_q;

    logic [CHUNK:0]              add_d;
    logic [1:0]                  top_d;

    // Carry vector is stored pre-shifted, so chunk k of both vectors share weights.
    always_comb begin
        add_d = {1'b0, sum_q[idx_q]} + {1'b0, car_lo_q[idx_q]} + {{CHUNK{1'b0}}, cy_q};
        top_d = {1'b0, car_top_q} + {1'b0, add_d[CHUNK]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            car_lo_q    <= '0;
            car_top_q   <= 1'b0;
            idx_q       <= '0;
            cy_q        <= 1'b0;
            res_lo_q    <= '0;
            res_hi_q    <= 2'b00;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sum_q                 <= s_in;
                        {car_top_q, car_lo_q} <= {c_in, 1'b0};
                        idx_q                 <= '0;
                        cy_q                  <= 1'b0;
                        state_q               <= S_ADD;
                    end
                end
                S_ADD: begin
                    res_lo_q[idx_q] <= add_d[CHUNK-1:0];
                    cy_q            <= add_d[CHUNK];
                    if (idx_q == LAST_IDX) begin
                        res_hi_q    <= top_d;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = {res_hi_q, res_lo_q};

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve.sv
`default_nettype none
// tb_csa_resolve: scoreboard bench; expected sums come from plain integer arithmetic.
module tb_csa_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] s_in = '0;
    logic [31:0] c_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [33:0] result;

    logic        rand_rdy  = 1'b0;
    logic        rdy_force = 1'b0;

    logic [33:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;
    int          n_out  = 0;

    csa_resolve #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [33:0] act, input logic [33:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Sole driver of out_ready; updated mid-cycle, well clear of both edges.
    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Monitor: pops one expectation per output handshake; also watches stall stability.
    logic        held = 1'b0;
    logic [33:0] held_val = '0;
    always @(negedge clk) begin
        if (out_valid) begin
            if (held) check("stall_stable", result, held_val);
            held     = !out_ready;
            held_val = result;
            if (out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 34'd1, 34'd0);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] s, input logic [31:0] c, input logic [33:0] e);
        int  n  = 0;
        bit  ok = 1'b0;
        in_valid = 1'b1;
        s_in     = s;
        c_in     = c;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) begin
            exp_q.push_back(e);
            n_acc++;
        end else begin
            check("accept_timeout", 34'd0, 34'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) check("drain_timeout", 34'd0, 34'd1);
    endtask

    function automatic logic [33:0] ref_res(input logic [31:0] s, input logic [31:0] c);
        return 34'(s) + 34'(2) * 34'(c);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, x, sv, cv;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 34'(in_ready), 34'd0);
        check("rst_out_valid", 34'(out_valid), 34'd0);
        check("rst_result", result, 34'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 34'(in_ready), 34'd1);
        @(posedge clk);
        #1;

        // Basic with latency: out_valid after exactly 4 edges, in_ready low meanwhile
        send(32'h1, 32'h1, 34'h3);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("lat_out_valid", 34'(out_valid), (k == 4) ? 34'd1 : 34'd0);
            check("busy_in_ready", 34'(in_ready), 34'd0);
        end
        rdy_force = 1'b1;
        drain();

        // Full ripple and maximum
        send(32'hFFFF_FFFF, 32'h1, 34'h1_0000_0001);
        drain();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 34'h2_FFFF_FFFD);
        drain();

        // Back-to-back with out_ready high: accept every N+2 = 6 cycles
        begin
            int t0, t1;
            send(32'h10, 32'h20, ref_res(32'h10, 32'h20));
            t0 = $time;
            send(32'h30, 32'h40, ref_res(32'h30, 32'h40));
            t1 = $time;
            check("throughput_cycles", 34'((t1 - t0) / 10), 34'd6);
            drain();
        end

        // Backpressure with new data offered during DONE
        rdy_force = 1'b0;
        send(32'h10, 32'h20, 34'h50);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("bp_valid_seen", 34'(out_valid), 34'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        s_in = 32'h7;
        c_in = 32'h3;
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", 34'(in_ready), 34'd0);
            check("bp_out_valid", 34'(out_valid), 34'd1);
            check("bp_result", result, 34'h50);
        end
        @(posedge clk);
        #1 rdy_force = 1'b1;
        @(posedge clk);
        #1 rdy_force = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", 34'(in_ready), 34'd1);
        if (in_ready) begin
            exp_q.push_back(34'hD);
            n_acc++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        rdy_force = 1'b1;
        drain();

        // Reset during the second ADD cycle, with in_valid also high during reset
        send(32'h123, 32'h456, ref_res(32'h123, 32'h456));
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        s_in = 32'hAAAA;
        c_in = 32'h5555;
        @(negedge clk);
        check("rst_mid_in_ready", 34'(in_ready), 34'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        void'(exp_q.pop_back());
        n_acc--;
        @(negedge clk);
        check("abort_out_valid", 34'(out_valid), 34'd0);
        check("abort_result", result, 34'd0);
        check("abort_in_ready", 34'(in_ready), 34'd1);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_output", 34'(out_valid), 34'd0);
        end
        @(posedge clk);
        #1;
        send(32'h5, 32'hA, 34'h19);
        drain();

        // Random vectors through a 3:2 compressor, random downstream stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a  = $urandom();
            b  = $urandom();
            x  = $urandom();
            sv = a ^ b ^ x;
            cv = (a & b) | (a & x) | (b & x);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(sv, cv, 34'(a) + 34'(b) + 34'(x));
        end
        drain();
        rand_rdy = 1'b0;
        check("out_count", 34'(n_out), 34'(n_acc));
        check("queue_empty", 34'(exp_q.size()), 34'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
